// File: rtl/fc_top.sv
// fc_top: LeNet fully-connected back end, FC1 (800->500, ReLU) then FC2 (500->10).
// Ports: conv_done/mem_sel start control; banks c/d feed FC1, bank e holds FC1
//   results and feeds FC2, bank f takes scores; 80-bit weight SRAM shared;
//   fc1_done/fc2_done are level flags. srstn is an async active-high reset.
module fc_top #(
  parameter int WEIGHT_WIDTH           = 4,
  parameter int WEIGHT_NUM             = 20,
  parameter int DATA_WIDTH             = 8,
  parameter int DATA_NUM_PER_SRAM_ADDR = 4,
  parameter int WEIGHT_ADDR_WIDTH      = 15,
  parameter int FC_SHIFT               = 7
) (
  input  logic        clk,
  input  logic        srstn,
  input  logic        conv_done,
  input  logic        mem_sel,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_c0,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_c1,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_c2,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_c3,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_c4,
  output logic [9:0]  sram_raddr_c0,
  output logic [9:0]  sram_raddr_c1,
  output logic [9:0]  sram_raddr_c2,
  output logic [9:0]  sram_raddr_c3,
  output logic [9:0]  sram_raddr_c4,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_d0,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_d1,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_d2,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_d3,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_d4,
  output logic [9:0]  sram_raddr_d0,
  output logic [9:0]  sram_raddr_d1,
  output logic [9:0]  sram_raddr_d2,
  output logic [9:0]  sram_raddr_d3,
  output logic [9:0]  sram_raddr_d4,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_e0,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_e1,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_e2,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_e3,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_e4,
  output logic [9:0]  sram_raddr_e0,
  output logic [9:0]  sram_raddr_e1,
  output logic [9:0]  sram_raddr_e2,
  output logic [9:0]  sram_raddr_e3,
  output logic [9:0]  sram_raddr_e4,
  output logic        sram_write_enable_e0,
  output logic        sram_write_enable_e1,
  output logic        sram_write_enable_e2,
  output logic        sram_write_enable_e3,
  output logic        sram_write_enable_e4,
  output logic [3:0]  sram_bytemask_e,
  output logic [9:0]  sram_waddr_e,
  output logic [DATA_WIDTH-1:0] sram_wdata_e,
  output logic        sram_write_enable_f,
  output logic [3:0]  sram_bytemask_f,
  output logic [9:0]  sram_waddr_f,
  output logic [DATA_WIDTH-1:0] sram_wdata_f,
  input  logic [WEIGHT_WIDTH*WEIGHT_NUM-1:0] sram_rdata_weight,
  output logic [WEIGHT_ADDR_WIDTH-1:0]      sram_raddr_weight,
  output logic        fc1_done,
  output logic        fc2_done
);

  localparam int DW = DATA_WIDTH * DATA_NUM_PER_SRAM_ADDR;
  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam logic [8:0] FC1_LAST_O = 9'd499;
  localparam logic [8:0] FC2_LAST_O = 9'd9;
  localparam logic [5:0] FC1_LAST_J = 6'd39;
  localparam logic [5:0] FC2_LAST_J = 6'd24;
  localparam logic [WEIGHT_ADDR_WIDTH-1:0] FC2_BASE = 20000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FC1,
    S_FC2,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic start;
  logic fin1, fin2;

  logic       iss_act, iss_l2, iss_src_c;
  logic [8:0] iss_o;
  logic [5:0] iss_j;
  logic [WEIGHT_ADDR_WIDTH-1:0] w_addr;
  logic [5:0] last_j;
  logic [8:0] last_o;

  logic       p_act, p_l2, p_src_c, p_first, p_last;
  logic [8:0] p_o;

  logic [DW-1:0] dc [5];
  logic [DW-1:0] dd [5];
  logic [DW-1:0] de [5];
  logic [DW-1:0] dw [5];

  logic signed [DATA_WIDTH-1:0]   act_b;
  logic signed [WEIGHT_WIDTH-1:0] wt;
  logic signed [PW-1:0]           prod;
  logic signed [31:0] sum, acc, acc_next, sh;
  logic [DATA_WIDTH-1:0] y1, y2;

  logic [4:0] we_e;
  logic [6:0] wword;
  logic [2:0] wbank;

  assign start = conv_done &&
    (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clk or posedge srstn) begin
    if (srstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_FC1;
      S_FC1:  if (fin1)  state_d = S_FC2;
      S_FC2:  if (fin2)  state_d = S_DONE;
      S_DONE: if (start) state_d = S_FC1;
      default: state_d = S_IDLE;
    endcase
  end

  assign last_j = iss_l2 ? FC2_LAST_J : FC1_LAST_J;
  assign last_o = iss_l2 ? FC2_LAST_O : FC1_LAST_O;

  // Weight words for both layers are laid out back to back, so the
  // weight address is a plain counter across every chunk of a layer.
  always_ff @(posedge clk or posedge srstn) begin
    if (srstn) begin
      iss_act   <= 1'b0;
      iss_l2    <= 1'b0;
      iss_src_c <= 1'b0;
      iss_o     <= '0;
      iss_j     <= '0;
      w_addr    <= '0;
    end else if (start) begin
      iss_act   <= 1'b1;
      iss_l2    <= 1'b0;
      iss_src_c <= mem_sel;
      iss_o     <= '0;
      iss_j     <= '0;
      w_addr    <= '0;
    end else if (state_q == S_FC1 && fin1) begin
      iss_act <= 1'b1;
      iss_l2  <= 1'b1;
      iss_o   <= '0;
      iss_j   <= '0;
      w_addr  <= FC2_BASE;
    end else if (iss_act) begin
      w_addr <= w_addr + 1'b1;
      if (iss_j == last_j) begin
        iss_j <= '0;
        if (iss_o == last_o) iss_act <= 1'b0;
        else                 iss_o <= iss_o + 1'b1;
      end else begin
        iss_j <= iss_j + 1'b1;
      end
    end
  end

  logic c_on, d_on, e_on;
  logic [9:0] rd_addr;

  assign c_on = iss_act && !iss_l2 && iss_src_c;
  assign d_on = iss_act && !iss_l2 && !iss_src_c;
  assign e_on = iss_act && iss_l2;
  assign rd_addr = {4'b0, iss_j};

  assign sram_raddr_c0 = c_on ? rd_addr : '0;
  assign sram_raddr_c1 = c_on ? rd_addr : '0;
  assign sram_raddr_c2 = c_on ? rd_addr : '0;
  assign sram_raddr_c3 = c_on ? rd_addr : '0;
  assign sram_raddr_c4 = c_on ? rd_addr : '0;
  assign sram_raddr_d0 = d_on ? rd_addr : '0;
  assign sram_raddr_d1 = d_on ? rd_addr : '0;
  assign sram_raddr_d2 = d_on ? rd_addr : '0;
  assign sram_raddr_d3 = d_on ? rd_addr : '0;
  assign sram_raddr_d4 = d_on ? rd_addr : '0;
  assign sram_raddr_e0 = e_on ? rd_addr : '0;
  assign sram_raddr_e1 = e_on ? rd_addr : '0;
  assign sram_raddr_e2 = e_on ? rd_addr : '0;
  assign sram_raddr_e3 = e_on ? rd_addr : '0;
  assign sram_raddr_e4 = e_on ? rd_addr : '0;
  assign sram_raddr_weight = iss_act ? w_addr : '0;

  // Tags travel one cycle behind the addresses to meet the read data.
  always_ff @(posedge clk or posedge srstn) begin
    if (srstn) begin
      p_act   <= 1'b0;
      p_l2    <= 1'b0;
      p_src_c <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      p_o     <= '0;
    end else begin
      p_act   <= iss_act;
      p_l2    <= iss_l2;
      p_src_c <= iss_src_c;
      p_first <= (iss_j == '0);
      p_last  <= (iss_j == last_j);
      p_o     <= iss_o;
    end
  end

  assign dc[0] = sram_rdata_c0;
  assign dc[1] = sram_rdata_c1;
  assign dc[2] = sram_rdata_c2;
  assign dc[3] = sram_rdata_c3;
  assign dc[4] = sram_rdata_c4;
  assign dd[0] = sram_rdata_d0;
  assign dd[1] = sram_rdata_d1;
  assign dd[2] = sram_rdata_d2;
  assign dd[3] = sram_rdata_d3;
  assign dd[4] = sram_rdata_d4;
  assign de[0] = sram_rdata_e0;
  assign de[1] = sram_rdata_e1;
  assign de[2] = sram_rdata_e2;
  assign de[3] = sram_rdata_e3;
  assign de[4] = sram_rdata_e4;

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      dw[k] = p_l2 ? de[k] : (p_src_c ? dc[k] : dd[k]);
    end
  end

  // Element m of the 20-wide chunk sits in bank m/4, byte m%4 with
  // byte 0 in the top bits; weight m sits in nibble m.
  always_comb begin
    act_b = '0;
    wt    = '0;
    prod  = '0;
    sum   = '0;
    for (int m = 0; m < WEIGHT_NUM; m++) begin
      act_b = dw[m/4][DW-1-DATA_WIDTH*(m%4) -: DATA_WIDTH];
      wt    = sram_rdata_weight[WEIGHT_WIDTH*m +: WEIGHT_WIDTH];
      prod  = PW'(act_b) * PW'(wt);
      sum   = sum + {{(32-PW){prod[PW-1]}}, prod};
    end
  end

  assign acc_next = p_first ? sum : acc + sum;
  assign sh = acc_next >>> FC_SHIFT;

  always_comb begin
    y1 = sh[DATA_WIDTH-1:0];
    if (sh < 0)        y1 = '0;
    else if (sh > 127) y1 = 8'd127;
    y2 = sh[DATA_WIDTH-1:0];
    if (sh < -128)     y2 = 8'h80;
    else if (sh > 127) y2 = 8'd127;
  end

  always_ff @(posedge clk or posedge srstn) begin
    if (srstn)      acc <= '0;
    else if (p_act) acc <= acc_next;
  end

  assign wword = p_o[8:2];
  assign wbank = 3'(wword % 7'd5);

  always_ff @(posedge clk or posedge srstn) begin
    if (srstn) begin
      we_e                <= 5'h1F;
      sram_bytemask_e     <= 4'hF;
      sram_waddr_e        <= '0;
      sram_wdata_e        <= '0;
      sram_write_enable_f <= 1'b1;
      sram_bytemask_f     <= 4'hF;
      sram_waddr_f        <= '0;
      sram_wdata_f        <= '0;
      fin1                <= 1'b0;
      fin2                <= 1'b0;
    end else begin
      we_e                <= 5'h1F;
      sram_bytemask_e     <= 4'hF;
      sram_write_enable_f <= 1'b1;
      sram_bytemask_f     <= 4'hF;
      fin1                <= 1'b0;
      fin2                <= 1'b0;
      if (p_act && p_last && !p_l2) begin
        we_e            <= ~(5'b00001 << wbank);
        sram_bytemask_e <= ~(4'b1000 >> p_o[1:0]);
        sram_waddr_e    <= 10'(p_o / 9'd20);
        sram_wdata_e    <= y1;
        fin1            <= (p_o == FC1_LAST_O);
      end
      if (p_act && p_last && p_l2) begin
        sram_write_enable_f <= 1'b0;
        sram_bytemask_f     <= ~(4'b1000 >> p_o[1:0]);
        sram_waddr_f        <= {3'b0, wword};
        sram_wdata_f        <= y2;
        fin2                <= (p_o == FC2_LAST_O);
      end
    end
  end

  assign sram_write_enable_e0 = we_e[0];
  assign sram_write_enable_e1 = we_e[1];
  assign sram_write_enable_e2 = we_e[2];
  assign sram_write_enable_e3 = we_e[3];
  assign sram_write_enable_e4 = we_e[4];

  always_ff @(posedge clk or posedge srstn) begin
    if (srstn) begin
      fc1_done <= 1'b0;
      fc2_done <= 1'b0;
    end else if (start) begin
      fc1_done <= 1'b0;
      fc2_done <= 1'b0;
    end else begin
      if (fin1) fc1_done <= 1'b1;
      if (fin2) fc2_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_top.sv
// tb_fc_top: randomized and directed bench for fc_top with SRAM models
// and a per-element arithmetic reference of both FC layers.
module tb_fc_top;

  logic clk = 1'b0;
  logic srstn = 1'b0;
  logic conv_done = 1'b0;
  logic mem_sel = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] rd_c [5];
  logic [31:0] rd_d [5];
  logic [31:0] rd_e [5];
  logic [9:0]  ra_c [5];
  logic [9:0]  ra_d [5];
  logic [9:0]  ra_e [5];
  logic [4:0]  we_e;
  logic [3:0]  bm_e, bm_f;
  logic [9:0]  wa_e, wa_f;
  logic [7:0]  wd_e, wd_f;
  logic        we_f;
  logic [79:0] rd_w;
  logic [14:0] ra_w;
  logic        fc1_done, fc2_done;

  fc_top dut (
    .clk(clk), .srstn(srstn),
    .conv_done(conv_done), .mem_sel(mem_sel),
    .sram_rdata_c0(rd_c[0]), .sram_rdata_c1(rd_c[1]),
    .sram_rdata_c2(rd_c[2]), .sram_rdata_c3(rd_c[3]),
    .sram_rdata_c4(rd_c[4]),
    .sram_raddr_c0(ra_c[0]), .sram_raddr_c1(ra_c[1]),
    .sram_raddr_c2(ra_c[2]), .sram_raddr_c3(ra_c[3]),
    .sram_raddr_c4(ra_c[4]),
    .sram_rdata_d0(rd_d[0]), .sram_rdata_d1(rd_d[1]),
    .sram_rdata_d2(rd_d[2]), .sram_rdata_d3(rd_d[3]),
    .sram_rdata_d4(rd_d[4]),
    .sram_raddr_d0(ra_d[0]), .sram_raddr_d1(ra_d[1]),
    .sram_raddr_d2(ra_d[2]), .sram_raddr_d3(ra_d[3]),
    .sram_raddr_d4(ra_d[4]),
    .sram_rdata_e0(rd_e[0]), .sram_rdata_e1(rd_e[1]),
    .sram_rdata_e2(rd_e[2]), .sram_rdata_e3(rd_e[3]),
    .sram_rdata_e4(rd_e[4]),
    .sram_raddr_e0(ra_e[0]), .sram_raddr_e1(ra_e[1]),
    .sram_raddr_e2(ra_e[2]), .sram_raddr_e3(ra_e[3]),
    .sram_raddr_e4(ra_e[4]),
    .sram_write_enable_e0(we_e[0]), .sram_write_enable_e1(we_e[1]),
    .sram_write_enable_e2(we_e[2]), .sram_write_enable_e3(we_e[3]),
    .sram_write_enable_e4(we_e[4]),
    .sram_bytemask_e(bm_e), .sram_waddr_e(wa_e), .sram_wdata_e(wd_e),
    .sram_write_enable_f(we_f), .sram_bytemask_f(bm_f),
    .sram_waddr_f(wa_f), .sram_wdata_f(wd_f),
    .sram_rdata_weight(rd_w), .sram_raddr_weight(ra_w),
    .fc1_done(fc1_done), .fc2_done(fc2_done)
  );

  logic [31:0] mc [5][1024];
  logic [31:0] md [5][1024];
  logic [31:0] me [5][1024];
  logic [31:0] mf [1024];
  logic [79:0] mw [32768];

  logic        fill_req = 1'b0;
  logic [31:0] fill_e = 32'hA5A5A5A5;
  logic [31:0] fill_f = 32'h5A5A5A5A;

  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      rd_c[k] <= mc[k][ra_c[k]];
      rd_d[k] <= md[k][ra_d[k]];
    end
    rd_w <= mw[ra_w];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) rd_e[k] <= me[k][ra_e[k]];
    if (fill_req) begin
      for (int a = 0; a < 1024; a++) begin
        for (int k = 0; k < 5; k++) me[k][a] <= fill_e;
        mf[a] <= fill_f;
      end
    end else begin
      for (int k = 0; k < 5; k++)
        if (!we_e[k])
          for (int b = 0; b < 4; b++)
            if (!bm_e[b]) me[k][wa_e][8*b +: 8] <= wd_e;
      if (!we_f)
        for (int b = 0; b < 4; b++)
          if (!bm_f[b]) mf[wa_f][8*b +: 8] <= wd_f;
    end
  end

  int e_wr = 0, f_wr = 0, multi = 0, bad = 0;
  int c_nz = 0, d_nz = 0;
  logic [3:0] mask5 = 4'hF;

  always @(negedge clk) begin
    if (!srstn) begin
      e_wr <= e_wr + $countones(~we_e);
      f_wr <= f_wr + 32'(!we_f);
      if ($countones(~we_e) > 1) multi <= multi + 1;
      if (($countones(~we_e) == 0 && bm_e != 4'hF) ||
          ($countones(~we_e) != 0 && $countones(~bm_e) != 1) ||
          (we_f && bm_f != 4'hF) ||
          (!we_f && $countones(~bm_f) != 1))
        bad <= bad + 1;
      if ((ra_c[0] | ra_c[1] | ra_c[2] | ra_c[3] | ra_c[4]) != 0)
        c_nz <= c_nz + 1;
      if ((ra_d[0] | ra_d[1] | ra_d[2] | ra_d[3] | ra_d[4]) != 0)
        d_nz <= d_nz + 1;
      if (!we_e[1] && wa_e == 10'd0 && wd_e == 8'd6) mask5 <= bm_e;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int act [800];
  logic signed [3:0] w1 [500][800];
  logic signed [3:0] w2 [10][500];
  int y1 [500];
  int y2 [10];

  task automatic model();
    int s;
    for (int o = 0; o < 500; o++) begin
      s = 0;
      for (int n = 0; n < 800; n++) s += act[n] * w1[o][n];
      s = s >>> 7;
      y1[o] = s < 0 ? 0 : (s > 127 ? 127 : s);
    end
    for (int o = 0; o < 10; o++) begin
      s = 0;
      for (int n = 0; n < 500; n++) s += y1[n] * w2[o][n];
      s = s >>> 7;
      y2[o] = s < -128 ? -128 : (s > 127 ? 127 : s);
    end
  endtask

  task automatic load(input bit sel);
    int w;
    for (int k = 0; k < 5; k++)
      for (int a = 0; a < 1024; a++) begin
        mc[k][a] = $urandom;
        md[k][a] = $urandom;
      end
    for (int n = 0; n < 800; n++) begin
      w = n / 4;
      if (sel) mc[w%5][w/5][31-8*(n%4) -: 8] = 8'(act[n]);
      else     md[w%5][w/5][31-8*(n%4) -: 8] = 8'(act[n]);
    end
    for (int a = 0; a < 32768; a++) mw[a] = '0;
    for (int o = 0; o < 500; o++)
      for (int n = 0; n < 800; n++)
        mw[o*40 + n/20][4*(n%20) +: 4] = w1[o][n];
    for (int o = 0; o < 10; o++)
      for (int n = 0; n < 500; n++)
        mw[20000 + o*25 + n/20][4*(n%20) +: 4] = w2[o][n];
    @(negedge clk);
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  function automatic logic [31:0] e_byte(input int o);
    int w;
    w = o / 4;
    return {24'b0, me[w%5][w/5][31-8*(o%4) -: 8]};
  endfunction

  function automatic logic [31:0] f_byte(input int o);
    return {24'b0, mf[o/4][31-8*(o%4) -: 8]};
  endfunction

  task automatic run(input bit sel);
    int cyc, cyc2;
    int e0, f0, m0, b0, nz0;
    e0 = e_wr; f0 = f_wr; m0 = multi; b0 = bad;
    nz0 = sel ? d_nz : c_nz;
    model();
    @(negedge clk);
    mem_sel = sel;
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    mem_sel = ~sel;
    chk("start_clr_fc1", 32'(fc1_done), 0);
    chk("start_clr_fc2", 32'(fc2_done), 0);
    chk("issue0_waddr", 32'(ra_w), 0);
    @(negedge clk);
    chk("issue1_waddr", 32'(ra_w), 1);
    chk("issue1_daddr", 32'(sel ? ra_c[2] : ra_d[2]), 1);
    cyc = 1;
    while (!fc1_done && cyc < 20100) begin
      @(negedge clk);
      cyc++;
      conv_done = (cyc == 1000);
    end
    conv_done = 1'b0;
    chk("fc1_done_seen", 32'(fc1_done), 1);
    chk("fc1_budget", 32'(cyc > 20016), 0);
    chk("fc2_after_fc1", 32'(fc2_done), 0);
    cyc2 = 0;
    while (!fc2_done && cyc2 < 400) begin
      @(negedge clk);
      cyc2++;
      conv_done = (cyc2 == 50);
    end
    conv_done = 1'b0;
    chk("fc2_done_seen", 32'(fc2_done), 1);
    chk("fc2_budget", 32'(cyc2 > 266), 0);
    repeat (5) @(negedge clk);
    chk("fc1_hold", 32'(fc1_done), 1);
    chk("fc2_hold", 32'(fc2_done), 1);
    for (int o = 0; o < 500; o++)
      chk($sformatf("e_out%0d", o), e_byte(o), 32'(y1[o] & 255));
    for (int o = 0; o < 10; o++)
      chk($sformatf("f_out%0d", o), f_byte(o), 32'(y2[o] & 255));
    chk("f_w2_untouched", {16'b0, mf[2][15:0]}, {16'b0, fill_f[15:0]});
    chk("f_w3_untouched", mf[3], fill_f);
    chk("e_write_count", 32'(e_wr - e0), 500);
    chk("f_write_count", 32'(f_wr - f0), 10);
    chk("e_multi_strobe", 32'(multi - m0), 0);
    chk("strobe_mask_rule", 32'(bad - b0), 0);
    chk("idle_src_addr", 32'((sel ? d_nz : c_nz) - nz0), 0);
  endtask

  initial begin
    #1 srstn = 1'b1;
    #1;
    chk("rst_fc1_done", 32'(fc1_done), 0);
    chk("rst_fc2_done", 32'(fc2_done), 0);
    chk("rst_we_e", 32'(we_e), 32'h1F);
    chk("rst_we_f", 32'(we_f), 1);
    chk("rst_bm_e", 32'(bm_e), 32'hF);
    chk("rst_bm_f", 32'(bm_f), 32'hF);
    chk("rst_wa_e", 32'(wa_e), 0);
    chk("rst_wd_f", 32'(wd_f), 0);
    chk("rst_ra_w", 32'(ra_w), 0);
    chk("rst_ra_c0", 32'(ra_c[0]), 0);
    repeat (2) @(negedge clk);
    srstn = 1'b0;

    for (int n = 0; n < 800; n++) act[n] = 1;
    for (int o = 0; o < 500; o++)
      for (int n = 0; n < 800; n++) w1[o][n] = 4'sd1;
    for (int o = 0; o < 10; o++)
      for (int n = 0; n < 500; n++) w2[o][n] = 4'sd1;
    load(1'b1);

    @(negedge clk);
    mem_sel = 1'b1;
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    repeat (700) @(negedge clk);
    chk("pre_abort_busy", 32'(ra_w != 0), 1);
    #1 srstn = 1'b1;
    #1;
    chk("abort_ra_w", 32'(ra_w), 0);
    chk("abort_ra_c", 32'(ra_c[0] | ra_c[3]), 0);
    chk("abort_we_e", 32'(we_e), 32'h1F);
    chk("abort_bm_e", 32'(bm_e), 32'hF);
    chk("abort_fc1_done", 32'(fc1_done), 0);
    @(negedge clk);
    srstn = 1'b0;

    run(1'b1);
    chk("ones_e", e_byte(0), 6);
    chk("ones_f", f_byte(9), 23);

    for (int n = 0; n < 800; n++) act[n] = 127;
    for (int o = 0; o < 500; o++)
      for (int n = 0; n < 800; n++) begin
        if (o == 5) w1[o][n] = (n == 0) ? 4'sd7 : 4'sd0;
        else if (o % 7 == 3) w1[o][n] = 4'($urandom_range(0, 15));
        else w1[o][n] = (o % 2 == 0) ? 4'sd7 : -4'sd8;
      end
    for (int o = 0; o < 10; o++)
      for (int n = 0; n < 500; n++)
        w2[o][n] = (o < 5) ? -4'sd8 : 4'($urandom_range(0, 15));
    load(1'b1);
    run(1'b1);
    chk("sat_127", e_byte(0), 127);
    chk("relu_0", e_byte(1), 0);
    chk("single_o5", e_byte(5), 6);
    chk("single_o5_mask", 32'(mask5), 32'b1011);
    chk("fc2_clamp_neg", f_byte(0), 32'h80);

    for (int n = 0; n < 800; n++)
      act[n] = int'($urandom_range(0, 255)) - 128;
    for (int o = 0; o < 500; o++)
      for (int n = 0; n < 800; n++)
        w1[o][n] = 4'($urandom_range(0, 15));
    for (int o = 0; o < 10; o++)
      for (int n = 0; n < 500; n++)
        w2[o][n] = 4'($urandom_range(0, 15));
    load(1'b0);
    run(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
